// File: rtl/wm_run_seq.sv
// Washing-machine run sequencer.
// Steps through fill / wash / drain / rinse / dry from settings latched at
// start, counts phase time on the 1 s tick, and drives the valve, drain and
// motor enables plus panel status. Every output is a flop so the actuator
// lines never glitch on a state change.
module wm_run_seq #(
  parameter int FILL_TIMEOUT = 120,
  parameter int DRAIN_SEC    = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] wash_sec,
  input  logic [7:0] rinse_sec,
  input  logic [7:0] dry_sec,
  input  logic [1:0] repeat_num,
  input  logic [7:0] water_target,
  input  logic       us_dist_en,
  input  logic [7:0] us_dist,
  output logic       valve_on,
  output logic       drain_on,
  output logic       motor_on,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic       busy,
  output logic       done_pulse,
  output logic       err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RINSE = 3'd4;
  localparam logic [2:0] S_DRY   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  localparam logic [7:0] FILL_T8  = 8'(FILL_TIMEOUT);
  localparam logic [7:0] DRAIN_T8 = 8'(DRAIN_SEC);

  logic [2:0] state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [7:0] wash_q, wash_d;
  logic [7:0] rinse_q, rinse_d;
  logic [7:0] dry_q, dry_d;
  logic [1:0] rep_q, rep_d;
  logic [7:0] target_q, target_d;
  logic [1:0] rinse_cnt_q, rinse_cnt_d;
  logic [2:0] naf_q, naf_d;
  logic       armed_q;
  logic       valve_q, valve_d;
  logic       drain_q, drain_d;
  logic       motor_q, motor_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       start_ok_s;
  logic       full_s;
  logic [1:0] eff_rep_s;
  logic       entering_s;
  logic       timed_s;
  logic [7:0] entry_dur_s;

  // A start that coincides with reset release is not acted on: armed_q is
  // still low in that first cycle.
  assign start_ok_s = start & armed_q;
  assign full_s     = us_dist_en & (us_dist <= target_q);
  assign eff_rep_s  = (rep_q == 2'd0) ? 2'd1 : rep_q;
  assign entering_s = (state_d != state_q);
  assign timed_s    = (state_q >= S_FILL) && (state_q <= S_DRY);

  // Next state, settings latch, rinse bookkeeping; stop overrides everything.
  always_comb begin
    state_d     = state_q;
    wash_d      = wash_q;
    rinse_d     = rinse_q;
    dry_d       = dry_q;
    rep_d       = rep_q;
    target_d    = target_q;
    rinse_cnt_d = rinse_cnt_q;
    naf_d       = naf_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok_s) begin
            wash_d      = wash_sec;
            rinse_d     = rinse_sec;
            dry_d       = dry_sec;
            rep_d       = repeat_num;
            target_d    = water_target;
            rinse_cnt_d = 2'd0;
            naf_d       = S_WASH;
            state_d     = S_FILL;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FILL: begin
          // A full reading beats a timeout seen in the same cycle.
          if (full_s) begin
            state_d = naf_q;
          end else if (remain_q == 8'd0) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_FILL;
          end
        end
        S_WASH, S_RINSE: begin
          if (remain_q == 8'd0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = state_q;
          end
        end
        S_DRAIN: begin
          if (remain_q == 8'd0) begin
            if (rinse_cnt_q < eff_rep_s) begin
              naf_d   = S_RINSE;
              state_d = S_FILL;
            end else begin
              state_d = S_DRY;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DRY: begin
          if (remain_q == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRY;
          end
        end
        S_DONE: begin
          if (start_ok_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      // Each refill heading into a rinse counts as one rinse pass.
      if ((state_d == S_FILL) && (state_q != S_FILL) && (naf_d == S_RINSE)) begin
        rinse_cnt_d = rinse_cnt_q + 2'd1;
      end else begin
        rinse_cnt_d = rinse_cnt_d;
      end
    end
  end

  // Duration loaded into the countdown when a state is entered.
  always_comb begin
    entry_dur_s = 8'd0;
    case (state_d)
      S_FILL:  entry_dur_s = FILL_T8;
      S_WASH:  entry_dur_s = wash_q;
      S_DRAIN: entry_dur_s = DRAIN_T8;
      S_RINSE: entry_dur_s = rinse_q;
      S_DRY:   entry_dur_s = dry_q;
      default: entry_dur_s = 8'd0;
    endcase
  end

  // Countdown: load on entry (so an entry-cycle tick is dropped), then
  // decrement on each tick, saturating at zero.
  always_comb begin
    remain_d = remain_q;
    if (stop) begin
      remain_d = 8'd0;
    end else if (entering_s) begin
      remain_d = entry_dur_s;
    end else if (tick_1s && timed_s && (remain_q != 8'd0)) begin
      remain_d = remain_q - 8'd1;
    end else begin
      remain_d = remain_q;
    end
  end

  // Output values for the state being entered, registered with it.
  always_comb begin
    valve_d = (state_d == S_FILL);
    drain_d = (state_d == S_DRAIN) || (state_d == S_DRY);
    motor_d = (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_DRY);
    busy_d  = (state_d >= S_FILL) && (state_d <= S_DRY);
    done_d  = (state_d == S_DONE) && (state_q != S_DONE);
    err_d   = (state_d == S_ERROR);
  end

  // State, settings and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      remain_q    <= 8'd0;
      wash_q      <= 8'd0;
      rinse_q     <= 8'd0;
      dry_q       <= 8'd0;
      rep_q       <= 2'd0;
      target_q    <= 8'd0;
      rinse_cnt_q <= 2'd0;
      naf_q       <= S_IDLE;
      armed_q     <= 1'b0;
      valve_q     <= 1'b0;
      drain_q     <= 1'b0;
      motor_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      wash_q      <= wash_d;
      rinse_q     <= rinse_d;
      dry_q       <= dry_d;
      rep_q       <= rep_d;
      target_q    <= target_d;
      rinse_cnt_q <= rinse_cnt_d;
      naf_q       <= naf_d;
      armed_q     <= 1'b1;
      valve_q     <= valve_d;
      drain_q     <= drain_d;
      motor_q     <= motor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign phase      = state_q;
  assign remain     = remain_q;
  assign valve_on   = valve_q;
  assign drain_on   = drain_q;
  assign motor_on   = motor_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_wm_run_seq.sv
// Self-checking bench for wm_run_seq: randomized ticks, distance readings,
// panel changes and stray start pulses, checked against the expected phase
// list, per-phase tick counts and entry durations derived from the settings.
module tb_wm_run_seq;

  localparam int FT = 5;
  localparam int DS = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_1s = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] wash_sec = 8'd0;
  logic [7:0] rinse_sec = 8'd0;
  logic [7:0] dry_sec = 8'd0;
  logic [1:0] repeat_num = 2'd0;
  logic [7:0] water_target = 8'd0;
  logic       us_dist_en = 1'b0;
  logic [7:0] us_dist = 8'd0;
  logic       valve_on, drain_on, motor_on, busy, done_pulse, err;
  logic [2:0] phase;
  logic [7:0] remain;

  int n_cmp = 0;
  int n_bad = 0;

  wm_run_seq #(.FILL_TIMEOUT(FT), .DRAIN_SEC(DS)) dut (
    .clk(clk), .rstn(rstn), .tick_1s(tick_1s), .start(start), .stop(stop),
    .wash_sec(wash_sec), .rinse_sec(rinse_sec), .dry_sec(dry_sec),
    .repeat_num(repeat_num), .water_target(water_target),
    .us_dist_en(us_dist_en), .us_dist(us_dist),
    .valve_on(valve_on), .drain_on(drain_on), .motor_on(motor_on),
    .phase(phase), .remain(remain), .busy(busy), .done_pulse(done_pulse), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    tick_1s = 1'b0; us_dist_en = 1'b0; start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  function automatic int exp_dur(input logic [2:0] ph, input logic [7:0] w, input logic [7:0] r, input logic [7:0] d);
    case (ph)
      3'd1:    return FT;
      3'd2:    return int'(w);
      3'd3:    return DS;
      3'd4:    return int'(r);
      3'd5:    return int'(d);
      default: return 0;
    endcase
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    step(); step();
    n_cmp++;
    if ({valve_on, drain_on, motor_on, busy, done_pulse, err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {valve_on, drain_on, motor_on, busy, done_pulse, err});
    end
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_cmp++;
    if (remain !== 8'd0) begin n_bad++; $display("FAIL reset_remain: got %0d want 0", remain); end
    rstn = 1'b1;
    step();
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL reset_release_phase: got %0d want 0", phase); end
  endtask

  // Run one whole program with randomized side stimulus and check it.
  task automatic run_program(input string tag, input logic [7:0] w, input logic [7:0] r,
                             input logic [7:0] d, input logic [1:0] rp, input logic [7:0] tgt);
    logic [63:0] seq_code, exp_code;
    logic [2:0]  prev;
    int exp_n, nph, eff, ticks, cycles, fills, dones;
    bit fill_chk, exp_exit, reached;
    logic [4:0] exp_flags;
    go_idle();
    eff = (rp == 2'd0) ? 1 : int'(rp);
    exp_code = 64'd0;
    exp_code = {exp_code[60:0], 3'd1}; exp_code = {exp_code[60:0], 3'd2}; exp_code = {exp_code[60:0], 3'd3};
    for (int i = 0; i < eff; i++) begin
      exp_code = {exp_code[60:0], 3'd1}; exp_code = {exp_code[60:0], 3'd4}; exp_code = {exp_code[60:0], 3'd3};
    end
    exp_code = {exp_code[60:0], 3'd5}; exp_code = {exp_code[60:0], 3'd6};
    exp_n = 5 + 3 * eff;
    seq_code = 64'd0; nph = 0; prev = 3'd0; ticks = 0; cycles = 0; fills = 0; dones = 0; reached = 1'b0;
    wash_sec = w; rinse_sec = r; dry_sec = d; repeat_num = rp; water_target = tgt;
    start = 1'b1;
    for (int k = 0; k < 4000 && !reached; k++) begin
      if (tick_1s && prev >= 3'd2 && prev <= 3'd5 && remain != 8'd0) ticks++;
      fill_chk = us_dist_en && (prev == 3'd1);
      exp_exit = (us_dist <= tgt);
      step();
      cycles++;
      exp_flags = {phase == 3'd1, phase == 3'd3 || phase == 3'd5,
                   phase == 3'd2 || phase == 3'd4 || phase == 3'd5,
                   phase >= 3'd1 && phase <= 3'd5, phase == 3'd7};
      n_cmp++;
      if ({valve_on, drain_on, motor_on, busy, err} !== exp_flags) begin
        n_bad++; $display("FAIL %s_flags ph%0d: got %b want %b", tag, phase, {valve_on, drain_on, motor_on, busy, err}, exp_flags);
      end
      if (done_pulse) dones++;
      if (fill_chk) begin
        n_cmp++;
        if ((phase != 3'd1) != exp_exit) begin
          n_bad++; $display("FAIL %s_fill_exit: got left=%0d want %0d", tag, phase != 3'd1, exp_exit);
        end
      end
      if (phase != prev) begin
        seq_code = {seq_code[60:0], phase}; nph++;
        if (prev >= 3'd2 && prev <= 3'd5) begin
          n_cmp++;
          if (ticks != exp_dur(prev, w, r, d)) begin
            n_bad++; $display("FAIL %s_ticks ph%0d: got %0d want %0d", tag, prev, ticks, exp_dur(prev, w, r, d));
          end
          if (exp_dur(prev, w, r, d) == 0) begin
            n_cmp++;
            if (cycles != 1) begin n_bad++; $display("FAIL %s_zero_len ph%0d: got %0d want 1", tag, prev, cycles); end
          end
        end
        n_cmp++;
        if (int'(remain) != exp_dur(phase, w, r, d)) begin
          n_bad++; $display("FAIL %s_entry ph%0d: got %0d want %0d", tag, phase, remain, exp_dur(phase, w, r, d));
        end
        if (phase == 3'd1) fills = 0;
        ticks = 0; cycles = 0; prev = phase;
        if (phase == 3'd6) reached = 1'b1;
      end
      start      = (prev >= 3'd1) && (prev <= 3'd5) && ($urandom_range(0, 15) == 0);
      tick_1s    = (prev != 3'd1) && (prev != 3'd6) && ($urandom_range(0, 2) == 0);
      us_dist_en = (prev == 3'd1) && ($urandom_range(0, 1) == 1);
      if (us_dist_en) begin
        us_dist = (fills < 2) ? 8'd30 : 8'd15;
        fills++;
      end else begin
        us_dist = 8'($urandom);
      end
      wash_sec = 8'($urandom); rinse_sec = 8'($urandom); dry_sec = 8'($urandom);
      repeat_num = 2'($urandom); water_target = 8'($urandom);
    end
    tick_1s = 1'b0; us_dist_en = 1'b0; start = 1'b0;
    n_cmp++;
    if (!reached) begin n_bad++; $display("FAIL %s_timeout: got phase %0d want 6", tag, phase); end
    n_cmp++;
    if (seq_code !== exp_code || nph != exp_n) begin
      n_bad++; $display("FAIL %s_seq: got %h/%0d want %h/%0d", tag, seq_code, nph, exp_code, exp_n);
    end
    n_cmp++;
    if (dones != 1) begin n_bad++; $display("FAIL %s_done_count: got %0d want 1", tag, dones); end
    step();
    n_cmp++;
    if ({phase, done_pulse, remain} !== {3'd6, 1'b0, 8'd0}) begin
      n_bad++; $display("FAIL %s_done_hold: got ph%0d dp%0d rem%0d want ph6 dp0 rem0", tag, phase, done_pulse, remain);
    end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL %s_done_exit: got %0d want 0", tag, phase); end
  endtask

  task automatic test_full_cycle();
    run_program("full", 8'd3, 8'd2, 8'd2, 2'd1, 8'd20);
  endtask

  task automatic test_repeat();
    run_program("rep0", 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 2'd0, 8'd20);
    run_program("rep3", 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)), 2'd3, 8'd20);
  endtask

  task automatic test_zero_duration();
    run_program("zero", 8'd0, 8'd1, 8'd0, 2'd1, 8'd20);
  endtask

  task automatic test_timeout();
    int ticks;
    go_idle();
    wash_sec = 8'd3; rinse_sec = 8'd2; dry_sec = 8'd2; repeat_num = 2'd1; water_target = 8'd20;
    us_dist = 8'd50;
    start = 1'b1; step(); start = 1'b0;
    ticks = 0;
    for (int k = 0; k < 200 && phase != 3'd7; k++) begin
      tick_1s = (k % 2 == 0);
      us_dist_en = (k % 3 == 0);
      if (tick_1s && phase == 3'd1 && remain != 8'd0) ticks++;
      step();
    end
    tick_1s = 1'b0; us_dist_en = 1'b0;
    n_cmp++;
    if (phase !== 3'd7) begin n_bad++; $display("FAIL timeout_phase: got %0d want 7", phase); end
    n_cmp++;
    if (ticks != FT) begin n_bad++; $display("FAIL timeout_ticks: got %0d want %0d", ticks, FT); end
    n_cmp++;
    if ({err, valve_on, busy} !== 3'b100) begin n_bad++; $display("FAIL timeout_flags: got %b want 100", {err, valve_on, busy}); end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if (phase !== 3'd7) begin n_bad++; $display("FAIL error_ignores_start: got %0d want 7", phase); end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if ({phase, err} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL error_stop: got ph%0d err%0d want ph0 err0", phase, err); end
  endtask

  task automatic test_stop_mid_wash();
    go_idle();
    wash_sec = 8'd5; rinse_sec = 8'd2; dry_sec = 8'd2; repeat_num = 2'd1; water_target = 8'd20;
    start = 1'b1; step(); start = 1'b0;
    us_dist = 8'd5; us_dist_en = 1'b1; step(); us_dist_en = 1'b0;
    n_cmp++;
    if ({phase, remain} !== {3'd2, 8'd5}) begin n_bad++; $display("FAIL stop_wash_entry: got ph%0d rem%0d want ph2 rem5", phase, remain); end
    for (int k = 0; k < 20 && remain != 8'd2; k++) begin
      tick_1s = 1'b1; step();
    end
    tick_1s = 1'b0;
    n_cmp++;
    if ({phase, remain} !== {3'd2, 8'd2}) begin n_bad++; $display("FAIL stop_wash_at2: got ph%0d rem%0d want ph2 rem2", phase, remain); end
    stop = 1'b1; step(); stop = 1'b0;
    n_cmp++;
    if ({phase, motor_on, busy, remain} !== {3'd0, 1'b0, 1'b0, 8'd0}) begin
      n_bad++; $display("FAIL stop_wash: got ph%0d m%0d b%0d rem%0d want ph0 m0 b0 rem0", phase, motor_on, busy, remain);
    end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if ({phase, valve_on, remain} !== {3'd1, 1'b1, 8'(FT)}) begin
      n_bad++; $display("FAIL restart: got ph%0d v%0d rem%0d want ph1 v1 rem%0d", phase, valve_on, remain, FT);
    end
    stop = 1'b1; step();
    start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL stop_with_start: got %0d want 0", phase); end
  endtask

  task automatic test_reset_mid_rinse();
    go_idle();
    wash_sec = 8'd0; rinse_sec = 8'd6; dry_sec = 8'd1; repeat_num = 2'd1; water_target = 8'd20;
    us_dist = 8'd5;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 100 && phase != 3'd4; k++) begin
      tick_1s = (phase != 3'd1);
      us_dist_en = (phase == 3'd1);
      step();
    end
    tick_1s = 1'b0; us_dist_en = 1'b0;
    n_cmp++;
    if ({phase, motor_on} !== {3'd4, 1'b1}) begin n_bad++; $display("FAIL reach_rinse: got ph%0d m%0d want ph4 m1", phase, motor_on); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({phase, motor_on, drain_on, valve_on, busy, remain} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      n_bad++; $display("FAIL async_reset: got ph%0d m%0d d%0d v%0d b%0d rem%0d want all 0", phase, motor_on, drain_on, valve_on, busy, remain);
    end
    step();
    rstn = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    n_cmp++;
    if (phase !== 3'd0) begin n_bad++; $display("FAIL start_at_release: got %0d want 0", phase); end
    start = 1'b1; step(); start = 1'b0;
    n_cmp++;
    if (phase !== 3'd1) begin n_bad++; $display("FAIL start_after_release: got %0d want 1", phase); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_timeout();
    test_repeat();
    test_zero_duration();
    test_stop_mid_wash();
    test_reset_mid_rinse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wm_run_seq.md
WM_RUN_SEQ -- requirements
Module: wm_run_seq

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 120, seconds allowed to reach water level before error.
REQ-002 SHALL have parameter DRAIN_SEC, default 10, drain duration in seconds.
REQ-003 SHALL have ports clk in 1 (system clock) and rstn in 1 (reset); reset rstn, asynchronous, active-low; clock clk.
REQ-004 SHALL have port tick_1s in 1: one-clk pulse per second from the top-level 1 s counter.
REQ-005 SHALL have ports start in 1 and stop in 1: one-clk debounced button pulses.
REQ-006 SHALL have ports wash_sec, rinse_sec and dry_sec, each in 8: phase durations in seconds from the control panel.
REQ-007 SHALL have port repeat_num in 2: rinse count; 0 is treated as 1.
REQ-008 SHALL have port water_target in 8: ultrasonic distance in cm at or below which the tub is full.
REQ-009 SHALL have ports us_dist_en in 1 (distance-valid pulse) and us_dist in 8 (distance in cm).
REQ-010 SHALL have outputs valve_on, drain_on and motor_on, each out 1: actuator enables.
REQ-011 SHALL have outputs phase out 3 (state code) and remain out 8 (seconds left, for the FND).
REQ-012 SHALL have outputs busy out 1, done_pulse out 1 and err out 1.

Function
REQ-013 SHALL implement states IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, DRY=5, DONE=6, ERROR=7; phase SHALL equal the state code, registered.
REQ-014 SHALL, in IDLE, on start: latch all settings, clear rinse_cnt, set next_after_fill=WASH, and enter FILL the next cycle.
REQ-015 SHALL ignore settings changes while not in IDLE.
REQ-016 SHALL ignore start in every state except IDLE and DONE.
REQ-017 SHALL, on entry to any timed state, load remain with that state's duration (FILL_TIMEOUT, wash, DRAIN_SEC, rinse, dry).
REQ-018 SHALL not count a tick_1s arriving in the entry cycle.
REQ-019 SHALL, on each later tick_1s, decrement remain, saturating at 0.
REQ-020 SHALL have FILL drive valve_on=1; entering FILL SHALL increment rinse_cnt when next_after_fill=RINSE.
REQ-021 SHALL leave FILL to next_after_fill on the cycle after us_dist_en=1 with us_dist<=water_target.
REQ-022 SHALL go from FILL to ERROR when remain reaches 0 before the tub is full; a full indication in the same cycle wins over the timeout.
REQ-023 SHALL have WASH and RINSE drive motor_on=1 and go to DRAIN when remain reaches 0; a duration of 0 SHALL exit one cycle after entry.
REQ-024 SHALL have DRAIN drive drain_on=1 and, at remain=0, go to FILL (next_after_fill=RINSE) if rinse_cnt<effective repeat_num, else to DRY.
REQ-025 SHALL have DRY drive motor_on=1 and drain_on=1, and go to DONE at remain=0.
REQ-026 SHALL assert done_pulse for exactly one cycle on DONE entry; DONE SHALL hold remain=0 and return to IDLE on start or stop.
REQ-027 SHALL hold all actuators off and err=1 in ERROR, exiting to IDLE only on stop.
REQ-028 SHALL treat stop as highest priority: from any state go to IDLE next cycle with actuators off and remain=0; stop with start simultaneously SHALL stay in IDLE.
REQ-029 SHALL drive busy=1 in FILL, WASH, DRAIN, RINSE and DRY only.
REQ-030 SHALL keep valve_on and drain_on never both 1 except in DRY, and valve_on=0 outside FILL.

Reset
REQ-031 SHALL, on rstn low, immediately set state IDLE, all outputs 0, rinse_cnt 0 and latched settings 0, including mid-cycle.

Verification
REQ-032 SHALL cover the full cycle: wash=3, rinse=2, dry=2, repeat=1, target=20, us_dist 30 then 15 -> phases 1,2,3,1,4,3,5,6; done_pulse once.
REQ-033 SHALL cover FILL timeout: FILL_TIMEOUT=5, us_dist fixed 50 -> ERROR after 5 ticks, err=1, valve_on=0; stop -> IDLE.
REQ-034 SHALL cover repeat: repeat_num=0 gives 1 rinse and repeat_num=3 gives 3 rinses (FILL entered 4 times).
REQ-035 SHALL cover stop mid-WASH with remain=2 -> IDLE next cycle, motor_on=0, remain=0; start then restarts at FILL.
REQ-036 SHALL cover zero duration: wash_sec=0 -> WASH lasts one cycle, then DRAIN with remain=DRAIN_SEC.
REQ-037 SHALL cover rstn asserted in RINSE -> outputs 0 asynchronously; start pulse in the same cycle as rstn release is ignored.
